assoc_cache: RTL and testbench
==============================

ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8, CPU byte-address width.
REQ-002 SHALL provide parameter INDEX_W, default 2, set-index bits; SETS = 2**INDEX_W.
REQ-003 SHALL provide parameter OFFSET_W, default 2, byte-offset bits; line = 2**OFFSET_W bytes; LINE_W = 8*2**OFFSET_W; TAG_W = ADDR_W-INDEX_W-OFFSET_W.
REQ-004 SHALL provide ports, clock and reset first:
- CLOCK  in  1  single clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- READ  in  1  CPU read request.
- WRITE  in  1  CPU write request.
- ADDRESS  in  ADDR_W  byte address: {tag, index, offset}.
- WRITEDATA  in  8  CPU write byte.
- READDATA  out  8  CPU read byte.
- BUSYWAIT  out  1  CPU stall.
- MREAD  out  1  memory line read.
- MWRITE  out  1  memory line write.
- MADDRESS  out  ADDR_W-OFFSET_W  line address {tag, index}.
- MWRITEDATA  out  LINE_W  line to memory.
- MREADDATA  in  LINE_W  line from memory.
- MBUSYWAIT  in  1  memory busy; low marks transfer done.

Function
REQ-005 SHALL be 2-way set-associative, write-back, write-allocate; per way per set: valid, dirty, tag, line; one LRU bit per set.
REQ-006 SHALL compute hit combinationally: a way is hit when valid and tag equals ADDRESS tag; at most one way hits.
REQ-007 SHALL, in IDLE, drive BUSYWAIT = (READ|WRITE) & !hit; BUSYWAIT SHALL be 1 in every non-IDLE state.
REQ-008 SHALL drive READDATA combinationally from the hit way's byte at offset; value when not hit is don't-care.
REQ-009 SHALL, on rising edge in IDLE with WRITE & hit, write WRITEDATA into the offset byte, set dirty.
REQ-010 SHALL, on rising edge in IDLE with any hit, set LRU to point to the way not accessed.
REQ-011 SHALL treat READ and WRITE both high as a write.
REQ-012 SHALL select victim: invalid way 0, else invalid way 1, else the LRU way.
REQ-013 SHALL implement states IDLE, WBACK, FETCH, UPDATE: IDLE->WBACK on miss with dirty victim; IDLE->FETCH on miss with clean/invalid victim; WBACK->FETCH when MBUSYWAIT low at an edge; FETCH->UPDATE when MBUSYWAIT low at an edge; UPDATE->IDLE unconditionally.
REQ-014 SHALL in WBACK drive MWRITE=1, MADDRESS={victim tag, index}, MWRITEDATA=victim line.
REQ-015 SHALL in FETCH drive MREAD=1, MADDRESS={ADDRESS tag, index}, capturing MREADDATA on the edge leaving FETCH.
REQ-016 SHALL in UPDATE install the line into the victim way: valid=1, dirty=0, tag=ADDRESS tag; the request then hits in IDLE one cycle later.
REQ-017 SHALL drive MREAD=MWRITE=0 in IDLE and UPDATE; MADDRESS/MWRITEDATA don't-care there.
REQ-018 SHALL hold ADDRESS, READ, WRITE, WRITEDATA stable while BUSYWAIT is high (CPU obligation); behaviour on change mid-miss is undefined.

Reset
REQ-019 SHALL, on RESET high, immediately clear all valid, dirty, LRU bits, force IDLE, drive MREAD=MWRITE=0; tags and data need not reset.
REQ-020 SHALL abort any WBACK/FETCH in progress on RESET without updating any line.

Configuration
REQ-021 SHALL, with macro ASSOC_CACHE_STATS_EN defined, add outputs HIT_COUNT and MISS_COUNT (16 bits each, reset 0, saturating at 0xFFFF): MISS_COUNT +1 on each IDLE->WBACK/FETCH edge; HIT_COUNT +1 on each IDLE hit edge excluding the first IDLE cycle after UPDATE.
REQ-022 SHALL, without ASSOC_CACHE_STATS_EN, omit both ports and counters entirely.

Verification (defaults; ADDRESS[7:4] tag, [3:2] index, [1:0] offset)
REQ-023 Reset, READ 0x00 -> BUSYWAIT=1, FETCH with MREAD=1, MADDRESS=0x00; MBUSYWAIT low -> UPDATE -> READDATA = byte 0 of MREADDATA, BUSYWAIT=0.
REQ-024 After 0x00 filled, READ 0x10 -> fills way1 via MADDRESS=0x04, no MWRITE; re-READ 0x00 and 0x10 both hit with BUSYWAIT=0 same cycle.
REQ-025 WRITE 0x02<=0x5A (hit way0) -> BUSYWAIT=0, LRU=way1; READ 0x20 -> evicts clean way1, MREAD MADDRESS=0x08, no MWRITE.
REQ-026 Then READ 0x30 -> victim way0 dirty: WBACK MWRITE=1, MADDRESS=0x00, MWRITEDATA[23:16]=0x5A, then FETCH MADDRESS=0x0C.
REQ-027 RESET asserted mid-FETCH -> MREAD=0 immediately, state IDLE; READ 0x00 afterwards misses.
REQ-028 With ASSOC_CACHE_STATS_EN: sequence REQ-023..REQ-026 -> MISS_COUNT=4, HIT_COUNT=3.

Source files
------------

// File: rtl/assoc_cache.sv
// 2-way set-associative, write-back, write-allocate byte cache with a line-wide memory port.
// Define ASSOC_CACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module assoc_cache #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INDEX_W  = 2,
  parameter int unsigned OFFSET_W = 2
) (
  input  logic                            CLOCK,
  input  logic                            RESET,
  input  logic                            READ,
  input  logic                            WRITE,
  input  logic [ADDR_W-1:0]               ADDRESS,
  input  logic [7:0]                      WRITEDATA,
  output logic [7:0]                      READDATA,
  output logic                            BUSYWAIT,
  output logic                            MREAD,
  output logic                            MWRITE,
  output logic [ADDR_W-OFFSET_W-1:0]      MADDRESS,
  output logic [(8<<OFFSET_W)-1:0]        MWRITEDATA,
  input  logic [(8<<OFFSET_W)-1:0]        MREADDATA,
  input  logic                            MBUSYWAIT
`ifdef ASSOC_CACHE_STATS_EN
  ,
  output logic [15:0]                     HIT_COUNT,
  output logic [15:0]                     MISS_COUNT
`endif
);

  localparam int unsigned SETS   = 1 << INDEX_W;
  localparam int unsigned LINE_W = 8 << OFFSET_W;
  localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {IDLE, WBACK, FETCH, UPDATE} state_t;

  state_t state_q, state_d;

  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   dirty_q [2];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q   [2][SETS];
  logic [LINE_W-1:0] data_q  [2][SETS];
  logic              victim_q;
  logic [LINE_W-1:0] fill_q;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_offset;
  logic                req;
  logic                hit0, hit1, hit, hit_way;
  logic                victim_d, victim_dirty;
  logic [LINE_W-1:0]   hit_line;

  assign req_tag    = ADDRESS[ADDR_W-1 -: TAG_W];
  assign req_index  = ADDRESS[OFFSET_W +: INDEX_W];
  assign req_offset = ADDRESS[OFFSET_W-1:0];
  assign req        = READ | WRITE;

  // Lookup: the fill path never installs a duplicate tag, so at most one way hits
  assign hit0    = valid_q[0][req_index] && (tag_q[0][req_index] == req_tag);
  assign hit1    = valid_q[1][req_index] && (tag_q[1][req_index] == req_tag);
  assign hit     = hit0 | hit1;
  assign hit_way = hit1;

  assign hit_line = data_q[hit_way][req_index];
  assign READDATA = hit_line[{req_offset, 3'b000} +: 8];

  // Victim: fill empty ways in order before evicting the least recently used one
  assign victim_d     = !valid_q[0][req_index] ? 1'b0 :
                        !valid_q[1][req_index] ? 1'b1 : lru_q[req_index];
  assign victim_dirty = valid_q[victim_d][req_index] && dirty_q[victim_d][req_index];

  always_comb begin
    state_d    = state_q;
    BUSYWAIT   = 1'b1;
    MREAD      = 1'b0;
    MWRITE     = 1'b0;
    MADDRESS   = {req_tag, req_index};
    MWRITEDATA = data_q[victim_q][req_index];
    case (state_q)
      IDLE: begin
        BUSYWAIT = req & ~hit;
        if (req && !hit) state_d = victim_dirty ? WBACK : FETCH;
      end
      WBACK: begin
        MWRITE   = 1'b1;
        MADDRESS = {tag_q[victim_q][req_index], req_index};
        if (!MBUSYWAIT) state_d = FETCH;
      end
      FETCH: begin
        MREAD = 1'b1;
        if (!MBUSYWAIT) state_d = UPDATE;
      end
      UPDATE: state_d = IDLE;
    endcase
  end

  // Control state: FSM, valid/dirty/LRU bits and the latched victim way
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      lru_q      <= '0;
      victim_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req && !hit) victim_q <= victim_d;
      if (state_q == IDLE && req && hit) begin
        lru_q[req_index] <= ~hit_way;
        if (WRITE) dirty_q[hit_way][req_index] <= 1'b1;
      end
      if (state_q == UPDATE) begin
        valid_q[victim_q][req_index] <= 1'b1;
        dirty_q[victim_q][req_index] <= 1'b0;
      end
    end
  end

  // Tag/data storage; valid bits clear asynchronously so no write can hit during reset
  always_ff @(posedge CLOCK) begin
    if (state_q == FETCH && !MBUSYWAIT) fill_q <= MREADDATA;
    if (state_q == IDLE && WRITE && hit)
      data_q[hit_way][req_index][{req_offset, 3'b000} +: 8] <= WRITEDATA;
    if (state_q == UPDATE) begin
      data_q[victim_q][req_index] <= fill_q;
      tag_q[victim_q][req_index]  <= req_tag;
    end
  end

`ifdef ASSOC_CACHE_STATS_EN
  logic after_update_q;

  // The retried access right after a fill is part of the miss, not a new hit
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      after_update_q <= 1'b0;
      HIT_COUNT      <= '0;
      MISS_COUNT     <= '0;
    end else begin
      after_update_q <= (state_q == UPDATE);
      if (state_q == IDLE && req && hit && !after_update_q && HIT_COUNT != 16'hFFFF)
        HIT_COUNT <= HIT_COUNT + 16'd1;
      if (state_q == IDLE && req && !hit && MISS_COUNT != 16'hFFFF)
        MISS_COUNT <= MISS_COUNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: directed fill/evict/reset sequences, a vector table, and
// randomized accesses checked against a recency-list cache model and a flat byte memory.
module tb_assoc_cache;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MREAD, MWRITE;
  logic [5:0]  MADDRESS;
  logic [31:0] MWRITEDATA, MREADDATA;
  logic        MBUSYWAIT;
`ifdef ASSOC_CACHE_STATS_EN
  logic [15:0] HIT_COUNT, MISS_COUNT;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [64];
  logic        auto_mem, mbusy_man, mem_load;
  int          mem_lat, mem_cnt;

  logic [7:0]  ref_mem [256];
  logic [3:0]  mtag   [4][2];
  bit          mdirty [4][2];
  int          mn     [4];

  always #5 CLOCK = ~CLOCK;

  assoc_cache dut (
    .CLOCK(CLOCK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT), .MREAD(MREAD),
    .MWRITE(MWRITE), .MADDRESS(MADDRESS), .MWRITEDATA(MWRITEDATA),
    .MREADDATA(MREADDATA), .MBUSYWAIT(MBUSYWAIT)
`ifdef ASSOC_CACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  // Line memory: busy for mem_lat cycles per transfer in auto mode, byte at address a = a after load
  assign MREADDATA = mem[MADDRESS];
  assign MBUSYWAIT = auto_mem ? (mem_cnt < mem_lat) : mbusy_man;

  always @(posedge CLOCK) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    end else if (MWRITE && !MBUSYWAIT) begin
      mem[MADDRESS] <= MWRITEDATA;
    end
    if (RESET || !(MREAD || MWRITE) || !MBUSYWAIT) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One CPU access, held until BUSYWAIT drops; reports what the memory side saw
  task automatic access(input logic wr, input logic both, input logic [7:0] addr,
                        input logic [7:0] wd, output logic miss, output logic wb,
                        output logic [5:0] wb_addr, output logic [31:0] wb_data,
                        output logic [5:0] fetch_addr, output logic [7:0] rd);
    int cyc;
    @(negedge CLOCK);
    READ = !wr || both; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
    #1;
    miss = BUSYWAIT; wb = 1'b0; wb_addr = '0; wb_data = '0; fetch_addr = '0; cyc = 0;
    while (BUSYWAIT && cyc < 200) begin
      if (MWRITE) begin wb = 1'b1; wb_addr = MADDRESS; wb_data = MWRITEDATA; end
      if (MREAD) fetch_addr = MADDRESS;
      @(negedge CLOCK); #1;
      cyc++;
    end
    if (cyc >= 200) check("access_timeout", 64'(cyc), 64'(0));
    rd = READDATA;
    @(posedge CLOCK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  // Per-set recency list: index 0 least recent, last index most recent
  task automatic model_access(input logic wr, input logic [7:0] addr, output logic miss,
                              output logic wb, output logic [5:0] wb_addr);
    int s, pos;
    logic [3:0] t;
    bit d;
    s = int'(addr[3:2]); t = addr[7:4]; pos = -1; wb = 1'b0; wb_addr = '0;
    for (int i = 0; i < mn[s]; i++) if (mtag[s][i] == t) pos = i;
    miss = (pos < 0);
    if (!miss) begin
      d = mdirty[s][pos] | wr;
      if (pos == 0 && mn[s] == 2) begin mtag[s][0] = mtag[s][1]; mdirty[s][0] = mdirty[s][1]; end
      mtag[s][mn[s]-1] = t; mdirty[s][mn[s]-1] = d;
    end else if (mn[s] == 2) begin
      wb = mdirty[s][0]; wb_addr = {mtag[s][0], addr[3:2]};
      mtag[s][0] = mtag[s][1]; mdirty[s][0] = mdirty[s][1];
      mtag[s][1] = t; mdirty[s][1] = wr;
    end else begin
      mtag[s][mn[s]] = t; mdirty[s][mn[s]] = wr; mn[s]++;
    end
    if (wr) ref_mem[addr] = 8'h00;
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wd;
    logic        exp_miss;
    logic        exp_wb;
    logic [5:0]  exp_wb_addr;
    logic [31:0] exp_wb_data;
    logic [5:0]  exp_fetch;
    logic        chk_rd;
    logic [7:0]  exp_rd;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic miss, wb;
    logic [5:0] wb_addr, fetch_addr, exp_wb_addr;
    logic [31:0] wb_data;
    logic [7:0] rd, addr, wd;
    logic exp_miss, exp_wb, wr, both;

    vecs[0] = '{1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 6'h00, 32'h0,         6'h04, 1'b1, 8'h10};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 6'h00, 32'h0,         6'h00, 1'b1, 8'h00};
    vecs[2] = '{1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 6'h00, 32'h0,         6'h00, 1'b1, 8'h10};
    vecs[3] = '{1'b1, 8'h02, 8'h5A, 1'b0, 1'b0, 6'h00, 32'h0,         6'h00, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 6'h00, 32'h0,         6'h08, 1'b1, 8'h20};
    vecs[5] = '{1'b0, 8'h30, 8'h00, 1'b1, 1'b1, 6'h00, 32'h035A0100, 6'h0C, 1'b1, 8'h30};

    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    auto_mem = 1'b0; mbusy_man = 1'b1; mem_load = 1'b1; mem_lat = 2;
    repeat (2) @(posedge CLOCK);
    mem_load = 1'b0;
    @(negedge CLOCK); #1;
    check("reset_busywait", 64'(BUSYWAIT), 64'(0));
    check("reset_mread", 64'(MREAD), 64'(0));
    check("reset_mwrite", 64'(MWRITE), 64'(0));
`ifdef ASSOC_CACHE_STATS_EN
    check("reset_hit_count", 64'(HIT_COUNT), 64'(0));
    check("reset_miss_count", 64'(MISS_COUNT), 64'(0));
`endif
    RESET = 1'b0;

    // Cold read miss with hand-driven memory handshake
    @(negedge CLOCK);
    READ = 1'b1; ADDRESS = 8'h00; #1;
    check("cold_busywait", 64'(BUSYWAIT), 64'(1));
    check("cold_idle_mread", 64'(MREAD), 64'(0));
    @(negedge CLOCK); #1;
    check("fetch_mread", 64'(MREAD), 64'(1));
    check("fetch_maddress", 64'(MADDRESS), 64'(6'h00));
    check("fetch_mwrite", 64'(MWRITE), 64'(0));
    @(negedge CLOCK); #1;
    check("fetch_hold_mread", 64'(MREAD), 64'(1));
    mbusy_man = 1'b0;
    @(negedge CLOCK); #1;
    mbusy_man = 1'b1;
    check("update_mread", 64'(MREAD), 64'(0));
    check("update_busywait", 64'(BUSYWAIT), 64'(1));
    @(negedge CLOCK); #1;
    check("filled_busywait", 64'(BUSYWAIT), 64'(0));
    check("filled_readdata", 64'(READDATA), 64'(8'h00));
    ADDRESS = 8'h03; #1;
    check("filled_offset3", 64'(READDATA), 64'(8'h03));
    @(posedge CLOCK); #1;
    READ = 1'b0;

    // Vector table: second way fill, hits, write hit, clean and dirty evictions
    auto_mem = 1'b1;
    for (int i = 0; i < 6; i++) begin
      access(vecs[i].wr, 1'b0, vecs[i].addr, vecs[i].wd, miss, wb, wb_addr, wb_data,
             fetch_addr, rd);
      check($sformatf("vec%0d_miss", i), 64'(miss), 64'(vecs[i].exp_miss));
      check($sformatf("vec%0d_wb", i), 64'(wb), 64'(vecs[i].exp_wb));
      if (vecs[i].exp_wb) begin
        check($sformatf("vec%0d_wb_addr", i), 64'(wb_addr), 64'(vecs[i].exp_wb_addr));
        check($sformatf("vec%0d_wb_data", i), 64'(wb_data), 64'(vecs[i].exp_wb_data));
      end
      if (vecs[i].exp_miss)
        check($sformatf("vec%0d_fetch", i), 64'(fetch_addr), 64'(vecs[i].exp_fetch));
      if (vecs[i].chk_rd)
        check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
    end
`ifdef ASSOC_CACHE_STATS_EN
    check("stats_miss_count", 64'(MISS_COUNT), 64'(4));
    check("stats_hit_count", 64'(HIT_COUNT), 64'(3));
`endif

    // Reset in the middle of a fetch
    auto_mem = 1'b0; mbusy_man = 1'b1;
    @(negedge CLOCK);
    READ = 1'b1; ADDRESS = 8'h40;
    @(negedge CLOCK); #1;
    check("abort_pre_mread", 64'(MREAD), 64'(1));
    #2 RESET = 1'b1; #1;
    check("abort_mread", 64'(MREAD), 64'(0));
    check("abort_mwrite", 64'(MWRITE), 64'(0));
    @(negedge CLOCK);
    RESET = 1'b0; READ = 1'b0;
    @(negedge CLOCK);
    READ = 1'b1; ADDRESS = 8'h30; #1;
    check("post_reset_miss", 64'(BUSYWAIT), 64'(1));
    @(negedge CLOCK); #1;
    check("post_reset_fetch", 64'(MREAD), 64'(1));
    mbusy_man = 1'b0;
    @(negedge CLOCK); #1;
    mbusy_man = 1'b1;
    @(negedge CLOCK); #1;
    check("post_reset_rdata", 64'(READDATA), 64'(8'h30));
    @(posedge CLOCK); #1;
    READ = 1'b0;

    // Randomized accesses against the reference model
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0; auto_mem = 1'b1;
    for (int a = 0; a < 256; a++) ref_mem[a] = mem[a >> 2][8*(a & 3) +: 8];
    for (int s = 0; s < 4; s++) mn[s] = 0;
    for (int n = 0; n < 300; n++) begin
      wr   = 1'($urandom_range(0, 2) == 0);
      both = 1'($urandom_range(0, 3) == 0);
      addr = {4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      wd   = 8'($urandom);
      mem_lat = $urandom_range(0, 3);
      model_access(wr, addr, exp_miss, exp_wb, exp_wb_addr);
      if (wr) ref_mem[addr] = wd;
      access(wr, both, addr, wd, miss, wb, wb_addr, wb_data, fetch_addr, rd);
      check("rand_miss", 64'(miss), 64'(exp_miss));
      check("rand_wb", 64'(wb), 64'(exp_wb));
      if (exp_wb && wb) check("rand_wb_addr", 64'(wb_addr), 64'(exp_wb_addr));
      if (exp_miss && miss) check("rand_fetch", 64'(fetch_addr), 64'(addr[7:2]));
      if (!wr) check("rand_rdata", 64'(rd), 64'(ref_mem[addr]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
